// File: rtl/sram_port_ctrl_if.sv
// Request/response bundle for sram_port_ctrl.
//   req_*  : valid/ready request stream (we, addr, wdata) from the initiator
//   rsp_*  : valid/ready read-response stream (data, addr) back to the initiator
// master = upstream datapath/DMA side, slave = the controller.
interface sram_port_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/sram_port_ctrl.sv
// Single-port SRAM initiator for the 32x1024 OpenRAM macro.
// Ports:
//   clk0, rstb0        : clock shared with the macro, synchronous active-low reset
//   bus (slave)        : request stream in, read-response stream out
//   init_done          : array clear finished (or skipped)
//   csb0/web0/addr0/din0 : registered macro command outputs
//   dout0              : macro read data, sampled two edges after the read is issued
module sram_port_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           RSP_DEPTH  = 4,
  parameter bit                    CLEAR_EN   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  sram_port_ctrl_if.slave       bus,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned PW  = $clog2(RSP_DEPTH);
  localparam int unsigned CNW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned UW  = $clog2(RSP_DEPTH + 3);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  accept, rd_accept;

  // Read pipeline: stage 1 = command on macro pins, stage 2 = macro capturing.
  logic                  rd_v1, rd_v2;
  logic [ADDR_WIDTH-1:0] rd_a1, rd_a2;

  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CNW-1:0]        count;
  logic [UW-1:0]         used;
  logic                  push, pop;

  // ---------------- FSM ----------------
  always_ff @(posedge clk0) begin
    if (!rstb0) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_last  = (clr_cnt == '1);
    unique case (state)
      S_RESET: state_nxt = CLEAR_EN ? S_CLEAR : S_RUN;
      S_CLEAR: if (clr_last) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_RESET;
    endcase
  end

  assign init_done = (state == S_RUN);

  // Credits cover reads still in the pipeline so a full FIFO can never overflow.
  always_comb begin
    used          = UW'(rd_v1) + UW'(rd_v2) + UW'(count);
    bus.req_ready = (state == S_RUN) && (used < UW'(RSP_DEPTH));
    accept        = bus.req_valid && bus.req_ready;
    rd_accept     = accept && !bus.req_we;
    push          = rd_v2;
    pop           = bus.rsp_valid && bus.rsp_ready;
  end

  // ---------------- macro command ----------------
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      csb0    <= 1'b1;
      web0    <= 1'b1;
      addr0   <= '0;
      din0    <= '0;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      csb0    <= 1'b0;
      web0    <= 1'b0;
      addr0   <= clr_cnt;
      din0    <= INIT_VALUE;
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end else if (accept) begin
      csb0  <= 1'b0;
      web0  <= !bus.req_we;
      addr0 <= bus.req_addr;
      din0  <= bus.req_wdata;
    end else begin
      csb0 <= 1'b1;
      web0 <= 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      rd_a1 <= '0;
      rd_a2 <= '0;
    end else begin
      rd_v1 <= rd_accept;
      rd_a1 <= bus.req_addr;
      rd_v2 <= rd_v1;
      rd_a2 <= rd_a1;
    end
  end

  // ---------------- response FIFO ----------------
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= dout0;
        fifo_addr[wr_ptr] <= rd_a2;
        wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid = (count != '0);
    bus.rsp_data  = fifo_data[rd_ptr];
    bus.rsp_addr  = fifo_addr[rd_ptr];
  end

endmodule
